// File: rtl/vga_pic_sprite.sv
// Bouncing-sprite pixel source: fetches an RGB332 picture from a synchronous ROM and
// emits latency-aligned RGB/syncs/blank. Optional macro PIC_SCALE2X_EN shows the sprite at 2x.
module vga_pic_sprite #(
  parameter int          PIC_W   = 160,
  parameter int          PIC_H   = 120,
  parameter int          ADDR_W  = 15,
  parameter int          ROM_LAT = 2,
  parameter int          STEP    = 2,
  parameter logic [23:0] BG_RGB  = 24'h000080
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [9:0]        iH_CNT,
  input  logic [9:0]        iV_CNT,
  input  logic              iDE,
  input  logic              iHS,
  input  logic              iVS,
  input  logic              iPAUSE,
  output logic [ADDR_W-1:0] oROM_ADDR,
  input  logic [7:0]        iROM_DATA,
  output logic [7:0]        oR,
  output logic [7:0]        oG,
  output logic [7:0]        oB,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [9:0]        oDBG_X0,
  output logic [9:0]        oDBG_Y0,
  output logic [1:0]        oDBG_STATE
);

`ifdef PIC_SCALE2X_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif
  localparam int FOOT_W = PIC_W << SCALE_SH;
  localparam int FOOT_H = PIC_H << SCALE_SH;
  localparam int XMAX   = 640 - FOOT_W;
  localparam int YMAX   = 480 - FOOT_H;
  localparam int DLY    = ROM_LAT + 1;

  // Bit 1 = moving up, bit 0 = moving left.
  typedef enum logic [1:0] {
    ST_DR = 2'b00,
    ST_DL = 2'b01,
    ST_UR = 2'b10,
    ST_UL = 2'b11
  } state_t;

  state_t     r_state;
  logic [9:0] r_x0;
  logic [9:0] r_y0;
  logic       r_vs_prev;
  logic       r_tick;

  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_l_next;
  logic       w_u_next;

  always_comb begin
    w_x_next = r_x0;
    w_l_next = r_state[0];
    if (!r_state[0]) begin
      if (11'({1'b0, r_x0}) + 11'(STEP) >= 11'(XMAX)) begin
        w_x_next = 10'(XMAX);
        w_l_next = 1'b1;
      end else begin
        w_x_next = r_x0 + 10'(STEP);
      end
    end else if (r_x0 <= 10'(STEP)) begin
      w_x_next = 10'd0;
      w_l_next = 1'b0;
    end else begin
      w_x_next = r_x0 - 10'(STEP);
    end
  end

  always_comb begin
    w_y_next = r_y0;
    w_u_next = r_state[1];
    if (!r_state[1]) begin
      if (11'({1'b0, r_y0}) + 11'(STEP) >= 11'(YMAX)) begin
        w_y_next = 10'(YMAX);
        w_u_next = 1'b1;
      end else begin
        w_y_next = r_y0 + 10'(STEP);
      end
    end else if (r_y0 <= 10'(STEP)) begin
      w_y_next = 10'd0;
      w_u_next = 1'b0;
    end else begin
      w_y_next = r_y0 - 10'(STEP);
    end
  end

  // Position only moves on the registered VS falling-edge pulse, so a frame never tears.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
      r_x0      <= 10'd0;
      r_y0      <= 10'd0;
      r_state   <= ST_DR;
    end else begin
      r_vs_prev <= iVS;
      r_tick    <= r_vs_prev & ~iVS;
      if (r_tick && !iPAUSE) begin
        r_x0    <= w_x_next;
        r_y0    <= w_y_next;
        r_state <= state_t'({w_u_next, w_l_next});
      end
    end
  end

  assign oDBG_X0    = r_x0;
  assign oDBG_Y0    = r_y0;
  assign oDBG_STATE = r_state;

  logic [10:0]       w_x_end;
  logic [10:0]       w_y_end;
  logic              w_win;
  logic [9:0]        w_rx;
  logic [9:0]        w_ry;
  logic [ADDR_W-1:0] w_lin;

  assign w_x_end = {1'b0, r_x0} + 11'(FOOT_W);
  assign w_y_end = {1'b0, r_y0} + 11'(FOOT_H);
  assign w_win   = iDE && (iH_CNT >= r_x0) && ({1'b0, iH_CNT} < w_x_end)
                       && (iV_CNT >= r_y0) && ({1'b0, iV_CNT} < w_y_end);
  assign w_rx    = (iH_CNT - r_x0) >> SCALE_SH;
  assign w_ry    = (iV_CNT - r_y0) >> SCALE_SH;
  assign w_lin   = ADDR_W'(w_ry) * ADDR_W'(PIC_W) + ADDR_W'(w_rx);

  // Bit DLY-1 of each shift register lines up with iROM_DATA for the same pixel.
  logic [DLY-1:0] r_de_sr;
  logic [DLY-1:0] r_win_sr;
  logic [DLY-1:0] r_hs_sr;
  logic [DLY-1:0] r_vs_sr;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oROM_ADDR <= '0;
      r_de_sr   <= '0;
      r_win_sr  <= '0;
      r_hs_sr   <= '1;
      r_vs_sr   <= '1;
    end else begin
      if (w_win) oROM_ADDR <= w_lin;
      r_de_sr  <= {r_de_sr[DLY-2:0], iDE};
      r_win_sr <= {r_win_sr[DLY-2:0], w_win};
      r_hs_sr  <= {r_hs_sr[DLY-2:0], iHS};
      r_vs_sr  <= {r_vs_sr[DLY-2:0], iVS};
    end
  end

  // Index 8'h00 is the transparency key and falls through to the background.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oR       <= 8'd0;
      oG       <= 8'd0;
      oB       <= 8'd0;
      oHS      <= 1'b1;
      oVS      <= 1'b1;
      oBLANK_n <= 1'b0;
    end else begin
      oHS      <= r_hs_sr[DLY-1];
      oVS      <= r_vs_sr[DLY-1];
      oBLANK_n <= r_de_sr[DLY-1];
      if (!r_de_sr[DLY-1]) begin
        oR <= 8'd0;
        oG <= 8'd0;
        oB <= 8'd0;
      end else if (r_win_sr[DLY-1] && (iROM_DATA != 8'h00)) begin
        oR <= {iROM_DATA[7:5], iROM_DATA[7:5], iROM_DATA[7:6]};
        oG <= {iROM_DATA[4:2], iROM_DATA[4:2], iROM_DATA[4:3]};
        oB <= {4{iROM_DATA[1:0]}};
      end else begin
        oR <= BG_RGB[23:16];
        oG <= BG_RGB[15:8];
        oB <= BG_RGB[7:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_pic_sprite.sv
// Self-checking bench for vga_pic_sprite: ROM model, random pixel streams against a
// screen-geometry reference, frame-by-frame bounce model, pause, sync latency and reset.
module tb_vga_pic_sprite;

`ifdef PIC_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam int          PIC_W   = 160;
  localparam int          PIC_H   = 120;
  localparam int          ROM_LAT = 2;
  localparam int          STEP    = 2;
  localparam logic [23:0] BG      = 24'h000080;
  localparam int          XMAX    = 640 - PIC_W * SC;
  localparam int          YMAX    = 480 - PIC_H * SC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        de = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        pause = 1'b0;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  r, g, b;
  logic        o_hs, o_vs, blank_n;
  logic [9:0]  dbg_x0, dbg_y0;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference sprite state: position and direction (+1 / -1 per axis).
  int mx = 0, my = 0, mdx = 1, mdy = 1;
  int exp_addr = 0;

  logic [7:0] mem [0:32767];
  logic [7:0] rp [0:3];

  always #20 clk = ~clk;

  // Synchronous ROM with ROM_LAT clocks from address to data.
  always @(posedge clk) begin
    rp[0] <= mem[rom_addr];
    for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
  end
  assign rom_data = rp[ROM_LAT-1];

  vga_pic_sprite dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iH_CNT(h_cnt), .iV_CNT(v_cnt),
    .iDE(de), .iHS(hs), .iVS(vs), .iPAUSE(pause),
    .oROM_ADDR(rom_addr), .iROM_DATA(rom_data),
    .oR(r), .oG(g), .oB(b), .oHS(o_hs), .oVS(o_vs), .oBLANK_n(blank_n),
    .oDBG_X0(dbg_x0), .oDBG_Y0(dbg_y0), .oDBG_STATE(dbg_state)
  );

  function automatic bit in_win(int h, int v);
    return (h >= mx) && (h < mx + PIC_W * SC) && (v >= my) && (v < my + PIC_H * SC);
  endfunction

  function automatic int pic_addr(int h, int v);
    return ((v - my) / SC) * PIC_W + (h - mx) / SC;
  endfunction

  function automatic logic [23:0] colour(logic [7:0] d);
    logic [7:0] bb;
    bb = {6'b0, d[1:0]} * 8'h55;
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], bb};
  endfunction

  // {blank_n, hs, vs, rgb} expected for one input pixel.
  function automatic logic [26:0] exp_pix(int h, int v, bit e, bit hh, bit vv);
    logic [23:0] rgb;
    logic [7:0]  d;
    if (!e) rgb = 24'h0;
    else if (in_win(h, v)) begin
      d   = mem[pic_addr(h, v)];
      rgb = (d == 8'h00) ? BG : colour(d);
    end else rgb = BG;
    return {e, hh, vv, rgb};
  endfunction

  function automatic void model_tick();
    if (pause) return;
    if (mdx > 0) begin
      if (mx + STEP >= XMAX) begin mx = XMAX; mdx = -1; end
      else mx = mx + STEP;
    end else begin
      if (mx <= STEP) begin mx = 0; mdx = 1; end
      else mx = mx - STEP;
    end
    if (mdy > 0) begin
      if (my + STEP >= YMAX) begin my = YMAX; mdy = -1; end
      else my = my + STEP;
    end else begin
      if (my <= STEP) begin my = 0; mdy = 1; end
      else my = my - STEP;
    end
  endfunction

  function automatic logic [21:0] exp_motion();
    logic [1:0] st;
    st = {mdy < 0, mdx < 0};
    return {10'(mx), 10'(my), st};
  endfunction

  task automatic do_tick();
    @(negedge clk) vs = 1'b0;
    repeat (2) @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({blank_n, o_hs, o_vs, r, g, b} !== {1'b0, 1'b1, 1'b1, 24'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", {blank_n, o_hs, o_vs, r, g, b}, {3'b011, 24'h0});
    end
    n_tests++;
    if ({rom_addr, dbg_x0, dbg_y0, dbg_state} !== 37'h0) begin
      n_fail++;
      $display("FAIL reset_state addr=%0d x0=%0d y0=%0d st=%0d exp all 0", rom_addr, dbg_x0, dbg_y0, dbg_state);
    end
  endtask

  task automatic test_pixel_directed();
    int          ch [3] = '{5, 5, 200};
    logic [7:0]  cd [3] = '{8'hE0, 8'h00, 8'hE0};
    logic [26:0] e;
    for (int i = 0; i < 3; i++) begin
      mem[pic_addr(5, 3)] = cd[i];
      @(negedge clk);
      h_cnt = 10'(ch[i]); v_cnt = 10'd3; de = 1'b1;
      e = exp_pix(ch[i], 3, 1'b1, 1'b1, 1'b1);
      if (in_win(ch[i], 3)) exp_addr = pic_addr(ch[i], 3);
      @(negedge clk) de = 1'b0;
      n_tests++;
      if (rom_addr !== 15'(exp_addr)) begin
        n_fail++;
        $display("FAIL directed_addr case=%0d got=%0d exp=%0d", i, rom_addr, exp_addr);
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (blank_n !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_early case=%0d blank_n=%b exp=0", i, blank_n);
      end
      @(negedge clk);
      n_tests++;
      if ({blank_n, o_hs, o_vs, r, g, b} !== e) begin
        n_fail++;
        $display("FAIL directed_pix case=%0d got=%h exp=%h", i, {blank_n, o_hs, o_vs, r, g, b}, e);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_random_pixels(input int n);
    logic [26:0] exp_q [$];
    logic [26:0] e;
    int h, v;
    bit dd, hh;
    for (int k = 0; k < n + 4; k++) begin
      @(negedge clk);
      if (exp_q.size() >= 4) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({blank_n, o_hs, o_vs, r, g, b} !== e) begin
          n_fail++;
          $display("FAIL random_pix k=%0d x0=%0d y0=%0d got=%h exp=%h", k, mx, my,
                   {blank_n, o_hs, o_vs, r, g, b}, e);
        end
      end
      if (k < n) begin
        dd = ($urandom_range(0, 4) != 0);
        hh = ($urandom_range(0, 7) != 0);
        if (!dd) begin
          h = $urandom_range(0, 1023);
          v = $urandom_range(0, 1023);
        end else if ($urandom_range(0, 1) == 0) begin
          h = $urandom_range(0, 639);
          v = $urandom_range(0, 479);
        end else begin
          h = mx + $urandom_range(0, PIC_W * SC + 8) - 4;
          v = my + $urandom_range(0, PIC_H * SC + 8) - 4;
          if (h < 0) h = 0;
          if (h > 639) h = 639;
          if (v < 0) v = 0;
          if (v > 479) v = 479;
        end
      end else begin
        dd = 1'b0; hh = 1'b1; h = 0; v = 0;
      end
      h_cnt = 10'(h); v_cnt = 10'(v); de = dd; hs = hh;
      exp_q.push_back(exp_pix(h, v, dd, hh, 1'b1));
    end
    hs = 1'b1;
  endtask

  task automatic test_motion(input int n);
    for (int t = 0; t < n; t++) begin
      do_tick();
      model_tick();
      n_tests++;
      if ({dbg_x0, dbg_y0, dbg_state} !== exp_motion()) begin
        n_fail++;
        $display("FAIL motion x0=%0d y0=%0d st=%0d exp x0=%0d y0=%0d st=%0d", dbg_x0, dbg_y0,
                 dbg_state, mx, my, exp_motion() & 22'h3);
      end
    end
  endtask

  task automatic test_pause();
    logic [21:0] held;
    held = exp_motion();
    @(negedge clk) pause = 1'b1;
    for (int t = 0; t < 10; t++) begin
      do_tick();
      model_tick();
      n_tests++;
      if ({dbg_x0, dbg_y0, dbg_state} !== held) begin
        n_fail++;
        $display("FAIL pause got=%h exp=%h", {dbg_x0, dbg_y0, dbg_state}, held);
      end
    end
    @(negedge clk) pause = 1'b0;
  endtask

  task automatic test_sync_latency();
    logic exp_hs;
    @(negedge clk) hs = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_hs = (k >= 4 && k <= 6) ? 1'b0 : 1'b1;
      n_tests++;
      if (o_hs !== exp_hs) begin
        n_fail++;
        $display("FAIL hs_latency k=%0d got=%b exp=%b", k, o_hs, exp_hs);
      end
      if (k == 3) hs = 1'b1;
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    h_cnt = 10'(mx + 1); v_cnt = 10'(my + 1); de = 1'b1;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({blank_n, o_hs, o_vs, r, g, b, rom_addr, dbg_x0, dbg_y0, dbg_state} !==
        {3'b011, 24'h0, 37'h0}) begin
      n_fail++;
      $display("FAIL midframe_reset got=%h", {blank_n, o_hs, o_vs, r, g, b, rom_addr, dbg_x0, dbg_y0, dbg_state});
    end
    @(negedge clk) de = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    mx = 0; my = 0; mdx = 1; mdy = 1; exp_addr = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_tests++;
      if ({blank_n, r, g, b} !== 25'h0) begin
        n_fail++;
        $display("FAIL post_reset_blank k=%0d got=%h exp=0", k, {blank_n, r, g, b});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < 4; i++) rp[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_pixel_directed();
    test_random_pixels(300);
    test_motion(70);
    test_random_pixels(300);
    test_pause();
    test_motion(170);
    test_sync_latency();
    test_motion(1200);
    test_random_pixels(200);
    test_motion(15);
    test_random_pixels(200);
    test_reset_midframe();
    test_random_pixels(100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
